// File: rtl/nanov_reg_port.sv
// nanov_reg_port: serial register-file access port, one 32-bit word per bus frame.
// Optional per-byte write masking under NANOV_REG_PORT_BYTEMASK_EN.
module nanov_reg_port (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cycle_start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_reg,
  input  logic [31:0] req_wdata,
`ifdef NANOV_REG_PORT_BYTEMASK_EN
  input  logic [3:0]  req_wmask,
`endif
  output logic [3:0]  rs1,
  input  logic        data_rs1,
  output logic [3:0]  rd,
  output logic        wr_en,
  output logic        data_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ALIGN, XFER, RESP} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        write_q;
  logic [3:0]  reg_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        live;
  logic        bit_act;
  logic [4:0]  n;
  logic        wbit;
  assign live    = state_q == ALIGN || state_q == XFER;
  assign bit_act = (state_q == ALIGN && cycle_start) || state_q == XFER;
  assign n       = state_q == XFER ? cnt_q : 5'd0;
`ifdef NANOV_REG_PORT_BYTEMASK_EN
  logic [3:0] wmask_q;
  // masked-off bytes rewrite the bit just read so the register keeps its old value
  assign wbit = wmask_q[n[4:3]] ? wdata_q[n] : data_rs1;
`else
  assign wbit = wdata_q[n];
`endif
  // rstn gates the strobe combinationally so an aborted write stops immediately
  assign wr_en     = rstn && bit_act && write_q && |reg_q;
  assign data_rd   = wr_en && wbit;
  assign rs1       = live ? reg_q : 4'd0;
  assign rd        = live ? reg_q : 4'd0;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_rdata = rdata_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      write_q <= 1'b0;
      reg_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef NANOV_REG_PORT_BYTEMASK_EN
      wmask_q <= 4'd0;
`endif
    end else begin
      if (bit_act && |reg_q) rdata_q[n] <= data_rs1;
      case (state_q)
        IDLE: if (req_valid) begin
          state_q <= ALIGN;
          write_q <= req_write;
          reg_q   <= req_reg;
          wdata_q <= req_wdata;
          rdata_q <= 32'd0;
`ifdef NANOV_REG_PORT_BYTEMASK_EN
          wmask_q <= req_wmask;
`endif
        end
        ALIGN: if (cycle_start) begin
          state_q <= XFER;
          cnt_q   <= 5'd1;
        end
        XFER: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= RESP;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nanov_reg_port.sv
// tb_nanov_reg_port: directed checks of nanov_reg_port against a serial register-file model.
module tb_nanov_reg_port;
  logic        clk = 0;
  logic        rstn;
  logic        cycle_start;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_reg;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic [3:0]  rs1;
  logic        data_rs1;
  logic [3:0]  rd;
  logic        wr_en;
  logic        data_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy;
  int          total = 0;
  int          passed = 0;
  logic [4:0]  ph = 5'd0;
  logic [31:0] rf [16] = '{0: 32'hFFFF0000, 3: 32'h0F0F0F0F, 5: 32'hDEADBEEF,
                           7: 32'h12345678, 9: 32'h11223344, default: 32'h0};
  logic [31:0] rdata;
  int          lat;
  logic        wseen;

  nanov_reg_port dut (
    .clk(clk), .rstn(rstn), .cycle_start(cycle_start), .req_valid(req_valid),
    .req_ready(req_ready), .req_write(req_write), .req_reg(req_reg), .req_wdata(req_wdata),
`ifdef NANOV_REG_PORT_BYTEMASK_EN
    .req_wmask(req_wmask),
`endif
    .rs1(rs1), .data_rs1(data_rs1), .rd(rd), .wr_en(wr_en), .data_rd(data_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  // free-running 32-bit bus frame; bit index on the bus equals ph
  always @(posedge clk) ph <= ph + 5'd1;
  always @(posedge clk) if (wr_en) rf[rd][ph] <= data_rd;
  assign cycle_start = ph == 5'd0;
  assign data_rs1    = rf[rs1][ph];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_data_rd"}, 32'(data_rd), 32'd0);
    chk({tag, "_rs1"}, 32'(rs1), 32'd0);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
  endtask

  // request presented in the cycle with ph==29, so first cycle_start is 3 cycles after accept
  task automatic issue(input logic w, input logic [3:0] r, input logic [31:0] wd, input logic [3:0] m);
    while (ph != 5'd29) @(negedge clk);
    req_valid = 1; req_write = w; req_reg = r; req_wdata = wd; req_wmask = m;
    @(negedge clk);
    req_valid = 0;
    chk("align_rs1", 32'(rs1), 32'(r));
    chk("align_busy", 32'(busy), 32'd1);
    chk("align_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic xact(input logic w, input logic [3:0] r, input logic [31:0] wd, input logic [3:0] m,
                      input int hold, output logic [31:0] rd_o, output int lat_o, output logic ws_o);
    issue(w, r, wd, m);
    lat_o = 0; ws_o = 0;
    while (!rsp_valid && lat_o < 40) begin
      ws_o |= wr_en;
      @(negedge clk);
      lat_o++;
    end
    rd_o = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, rd_o);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rstn = 0; req_valid = 0; req_write = 0; req_reg = 0; req_wdata = 0; req_wmask = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rstn = 1;
    xact(1'b0, 4'd5, 32'h0, 4'h0, 0, rdata, lat, wseen);
    chk("rd_x5_lat", 32'(lat), 32'd34);
    chk("rd_x5_data", rdata, 32'hDEADBEEF);
    chk("rd_x5_wr_en", 32'(wseen), 32'd0);
    xact(1'b1, 4'd7, 32'hA5A5A5A5, 4'hF, 0, rdata, lat, wseen);
    chk("wr_x7_lat", 32'(lat), 32'd34);
    chk("wr_x7_old", rdata, 32'h12345678);
    chk("wr_x7_wr_en", 32'(wseen), 32'd1);
    chk("wr_x7_rf", rf[7], 32'hA5A5A5A5);
    xact(1'b0, 4'd7, 32'h0, 4'h0, 0, rdata, lat, wseen);
    chk("rd_x7_data", rdata, 32'hA5A5A5A5);
    xact(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 0, rdata, lat, wseen);
    chk("wr_x0_wr_en", 32'(wseen), 32'd0);
    chk("wr_x0_rdata", rdata, 32'd0);
    chk("wr_x0_rf", rf[0], 32'hFFFF0000);
    xact(1'b0, 4'd5, 32'h0, 4'h0, 10, rdata, lat, wseen);
    chk("bp_x5_data", rdata, 32'hDEADBEEF);
    issue(1'b1, 4'd3, 32'hF0F0F0F0, 4'hF);
    while (ph != 5'd12) @(negedge clk);
    chk("abort_wr_en_before", 32'(wr_en), 32'd1);
    rstn = 0;
    #1;
    chk("abort_wr_en_now", 32'(wr_en), 32'd0);
    chk("abort_data_rd_now", 32'(data_rd), 32'd0);
    @(negedge clk);
    chk_reset("abort");
    rstn = 1;
    repeat (40) @(negedge clk);
    chk("abort_x3_rf", rf[3], 32'h0F0F00F0);
`ifdef NANOV_REG_PORT_BYTEMASK_EN
    xact(1'b1, 4'd9, 32'hAABBCCDD, 4'b0101, 0, rdata, lat, wseen);
    chk("mask_x9_old", rdata, 32'h11223344);
    chk("mask_x9_rf", rf[9], 32'h11BB33DD);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
